// File: rtl/writeback_unit_if.sv
// Writeback bus: ALU and load producer handshakes, register-file write port,
// and the decode-side hazard query. The slave modport is the writeback unit's
// view; the master modport is the surrounding pipeline's view.
interface writeback_unit_if #(
  parameter int unsigned WORDSIZE    = 64,
  parameter int unsigned REGADDRSIZE = 5,
  parameter int unsigned DEPTH       = 4
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic                   alu_valid;
  logic                   alu_ready;
  logic [REGADDRSIZE-1:0] alu_rd;
  logic [WORDSIZE-1:0]    alu_data;

  logic                   mem_valid;
  logic                   mem_ready;
  logic [REGADDRSIZE-1:0] mem_rd;
  logic [WORDSIZE-1:0]    mem_data;

  logic [REGADDRSIZE-1:0] rf_rd;
  logic [WORDSIZE-1:0]    rf_in;
  logic                   rf_wren;

  logic [REGADDRSIZE-1:0] chk_rn;
  logic [REGADDRSIZE-1:0] chk_rm;
  logic                   hazard_n;
  logic                   hazard_m;

  logic [CntW-1:0]        count;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  chk_rn, chk_rm,
    output alu_ready, mem_ready,
    output rf_rd, rf_in, rf_wren,
    output hazard_n, hazard_m,
    output count
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output chk_rn, chk_rm,
    input  alu_ready, mem_ready,
    input  rf_rd, rf_in, rf_wren,
    input  hazard_n, hazard_m,
    input  count
  );
endinterface

// File: rtl/writeback_unit.sv
// Write-side front end of the register file: merges ALU and load results into
// an in-order FIFO, drains one write per cycle, and flags pending writes to
// the two decode read addresses.
module writeback_unit #(
  parameter int unsigned WORDSIZE    = 64,
  parameter int unsigned REGADDRSIZE = 5,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned XZR         = 31
) (
  input logic             clk,
  input logic             reset,
  writeback_unit_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [REGADDRSIZE-1:0] ZeroReg = REGADDRSIZE'(XZR);

  // Entry storage; only valid entries are ever observed, so no reset needed.
  logic [REGADDRSIZE-1:0] rd_q   [DEPTH];
  logic [WORDSIZE-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0]       vld_q;

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  logic [CntW-1:0] free;
  logic            mem_ready, alu_ready;
  logic            mem_enq, alu_enq, deq;
  logic [PtrW-1:0] alu_slot;

  // Acceptance and pointer/count next state. Free space ignores the same-cycle
  // pop, so the buffer never has to forward a write through a full slot.
  always_comb begin
    free      = CntW'(DEPTH) - count_q;
    mem_ready = (free >= CntW'(1));
    alu_ready = bus.mem_valid ? (free >= CntW'(2)) : (free >= CntW'(1));
    // Writes to the zero register complete the handshake but are dropped.
    mem_enq   = bus.mem_valid && mem_ready && (bus.mem_rd != ZeroReg);
    alu_enq   = bus.alu_valid && alu_ready && (bus.alu_rd != ZeroReg);
    deq       = (count_q != '0);
    // Load is older than the ALU result when both arrive together.
    alu_slot  = tail_q + PtrW'(mem_enq);
    tail_d    = tail_q + PtrW'(mem_enq) + PtrW'(alu_enq);
    head_d    = head_q + PtrW'(deq);
    count_d   = count_q + CntW'(mem_enq) + CntW'(alu_enq) - CntW'(deq);
  end

  // Pointer, count and entry-valid state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      // An enqueue slot never coincides with the head being popped.
      if (deq)     vld_q[head_q]   <= 1'b0;
      if (mem_enq) vld_q[tail_q]   <= 1'b1;
      if (alu_enq) vld_q[alu_slot] <= 1'b1;
    end
  end

  // Entry payload capture.
  always_ff @(posedge clk) begin
    if (mem_enq) begin
      rd_q[tail_q]   <= bus.mem_rd;
      data_q[tail_q] <= bus.mem_data;
    end
    if (alu_enq) begin
      rd_q[alu_slot]   <= bus.alu_rd;
      data_q[alu_slot] <= bus.alu_data;
    end
  end

  // Register-file write port driven straight from the head entry.
  always_comb begin
    bus.rf_wren = deq;
    bus.rf_rd   = deq ? rd_q[head_q] : '0;
    bus.rf_in   = deq ? data_q[head_q] : '0;
  end

  // Hazard match over all buffered entries, including the one draining now.
  always_comb begin
    bus.hazard_n = 1'b0;
    bus.hazard_m = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (rd_q[i] == bus.chk_rn)) bus.hazard_n = 1'b1;
      if (vld_q[i] && (rd_q[i] == bus.chk_rm)) bus.hazard_m = 1'b1;
    end
    if (bus.chk_rn == ZeroReg) bus.hazard_n = 1'b0;
    if (bus.chk_rm == ZeroReg) bus.hazard_m = 1'b0;
  end

  assign bus.mem_ready = mem_ready;
  assign bus.alu_ready = alu_ready;
  assign bus.count     = count_q;
endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: inputs change on the falling edge and
// outputs are sampled 1 time unit later, well clear of the rising edge.
module tb_writeback_unit;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  writeback_unit_if #(.WORDSIZE(64), .REGADDRSIZE(5), .DEPTH(4)) bus ();

  writeback_unit #(
    .WORDSIZE   (64),
    .REGADDRSIZE(5),
    .DEPTH      (4),
    .XZR        (31)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one cycle of producer offers, then settle before sampling.
  task automatic offer(input logic mv, input logic [4:0] mrd, input logic [63:0] md,
                       input logic av, input logic [4:0] ard, input logic [63:0] ad);
    @(negedge clk);
    bus.mem_valid = mv;
    bus.mem_rd    = mrd;
    bus.mem_data  = md;
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = ad;
    #1;
  endtask

  task automatic idle();
    offer(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.chk_rn = '0; bus.chk_rm = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_wren", 64'(bus.rf_wren), 64'd0);
    check("rst_rd", 64'(bus.rf_rd), 64'd0);
    check("rst_in", bus.rf_in, 64'd0);
    check("rst_haz_n", 64'(bus.hazard_n), 64'd0);
    check("rst_haz_m", 64'(bus.hazard_m), 64'd0);
    reset = 1'b0;

    // 1: single ALU write
    bus.chk_rn = 5'd5;
    offer(1'b0, 5'd0, 64'h0, 1'b1, 5'd5, 64'hDEAD);
    check("t1_alu_ready", 64'(bus.alu_ready), 64'd1);
    check("t1_pre_haz", 64'(bus.hazard_n), 64'd0);
    check("t1_pre_wren", 64'(bus.rf_wren), 64'd0);
    idle();
    check("t1_wren", 64'(bus.rf_wren), 64'd1);
    check("t1_rd", 64'(bus.rf_rd), 64'd5);
    check("t1_in", bus.rf_in, 64'hDEAD);
    check("t1_haz", 64'(bus.hazard_n), 64'd1);
    check("t1_count", 64'(bus.count), 64'd1);
    idle();
    check("t1_wren_after", 64'(bus.rf_wren), 64'd0);
    check("t1_haz_after", 64'(bus.hazard_n), 64'd0);
    check("t1_count_after", 64'(bus.count), 64'd0);

    // 2: simultaneous load and ALU, load written first
    offer(1'b1, 5'd1, 64'h11, 1'b1, 5'd2, 64'h22);
    check("t2_mem_ready", 64'(bus.mem_ready), 64'd1);
    check("t2_alu_ready", 64'(bus.alu_ready), 64'd1);
    idle();
    check("t2_count", 64'(bus.count), 64'd2);
    check("t2_w0_rd", 64'(bus.rf_rd), 64'd1);
    check("t2_w0_in", bus.rf_in, 64'h11);
    idle();
    check("t2_w1_rd", 64'(bus.rf_rd), 64'd2);
    check("t2_w1_in", bus.rf_in, 64'h22);
    idle();
    check("t2_empty", 64'(bus.rf_wren), 64'd0);

    // 3: zero register accepted but dropped
    bus.chk_rn = 5'd31;
    offer(1'b0, 5'd0, 64'h0, 1'b1, 5'd31, 64'hFF);
    check("t3_alu_ready", 64'(bus.alu_ready), 64'd1);
    idle();
    check("t3_count", 64'(bus.count), 64'd0);
    check("t3_wren", 64'(bus.rf_wren), 64'd0);
    check("t3_haz", 64'(bus.hazard_n), 64'd0);

    // 4: both producers every cycle; with one write draining per cycle the
    // buffer settles at three entries and only the load is admitted there.
    offer(1'b1, 5'd10, 64'h100, 1'b1, 5'd20, 64'h200);
    check("t4_c0_count", 64'(bus.count), 64'd0);
    offer(1'b1, 5'd11, 64'h101, 1'b1, 5'd21, 64'h201);
    check("t4_c1_count", 64'(bus.count), 64'd2);
    check("t4_c1_alu_ready", 64'(bus.alu_ready), 64'd1);
    check("t4_c1_rd", 64'(bus.rf_rd), 64'd10);
    check("t4_c1_in", bus.rf_in, 64'h100);
    offer(1'b1, 5'd12, 64'h102, 1'b1, 5'd22, 64'h202);
    check("t4_c2_count", 64'(bus.count), 64'd3);
    check("t4_c2_mem_ready", 64'(bus.mem_ready), 64'd1);
    check("t4_c2_alu_ready", 64'(bus.alu_ready), 64'd0);
    check("t4_c2_rd", 64'(bus.rf_rd), 64'd20);
    check("t4_c2_in", bus.rf_in, 64'h200);
    idle();
    check("t4_c3_count", 64'(bus.count), 64'd3);
    check("t4_c3_rd", 64'(bus.rf_rd), 64'd11);
    idle();
    check("t4_c4_rd", 64'(bus.rf_rd), 64'd21);
    check("t4_c4_in", bus.rf_in, 64'h201);
    idle();
    check("t4_c5_rd", 64'(bus.rf_rd), 64'd12);
    check("t4_c5_count", 64'(bus.count), 64'd1);
    idle();
    check("t4_drained", 64'(bus.count), 64'd0);

    // 5: same destination, last write wins
    bus.chk_rn = 5'd7;
    offer(1'b1, 5'd7, 64'h1, 1'b0, 5'd0, 64'h0);
    check("t5_pre_haz", 64'(bus.hazard_n), 64'd0);
    offer(1'b0, 5'd0, 64'h0, 1'b1, 5'd7, 64'h2);
    check("t5_w0_in", bus.rf_in, 64'h1);
    check("t5_w0_haz", 64'(bus.hazard_n), 64'd1);
    idle();
    check("t5_w1_rd", 64'(bus.rf_rd), 64'd7);
    check("t5_w1_in", bus.rf_in, 64'h2);
    check("t5_w1_haz", 64'(bus.hazard_n), 64'd1);
    idle();
    check("t5_haz_clear", 64'(bus.hazard_n), 64'd0);

    // 6: reset pulse between edges with three entries buffered
    bus.chk_rn = 5'd5;
    bus.chk_rm = 5'd6;
    offer(1'b1, 5'd3, 64'h33, 1'b1, 5'd4, 64'h44);
    offer(1'b1, 5'd5, 64'h55, 1'b1, 5'd6, 64'h66);
    idle();
    check("t6_count", 64'(bus.count), 64'd3);
    check("t6_haz_n", 64'(bus.hazard_n), 64'd1);
    check("t6_haz_m", 64'(bus.hazard_m), 64'd1);
    check("t6_rd", 64'(bus.rf_rd), 64'd4);
    reset = 1'b1;
    #1;
    check("t6_rst_count", 64'(bus.count), 64'd0);
    check("t6_rst_wren", 64'(bus.rf_wren), 64'd0);
    check("t6_rst_haz_n", 64'(bus.hazard_n), 64'd0);
    check("t6_rst_haz_m", 64'(bus.hazard_m), 64'd0);
    check("t6_rst_in", bus.rf_in, 64'd0);
    reset = 1'b0;
    idle();
    check("t6_post_wren", 64'(bus.rf_wren), 64'd0);
    check("t6_post_count", 64'(bus.count), 64'd0);
    idle();
    check("t6_post2_wren", 64'(bus.rf_wren), 64'd0);
    check("t6_post2_haz", 64'(bus.hazard_n), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
